// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter for a single external 8-bit async SRAM.
// Each granted access runs a fixed-length cycle: address/data setup, WE# pulse, hold.
module sram_arbiter #(
   parameter int unsigned ACCESS_CYCLES = 4,
   parameter int unsigned AW            = 21
) (
   input  logic          sysclk,
   input  logic          rst_n,

   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [7:0]    a_wdata,
   output logic          a_ack,
   output logic [7:0]    a_rdata,

   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [7:0]    b_wdata,
   output logic          b_ack,
   output logic [7:0]    b_rdata,

   output logic [AW-1:0] sram_addr,
   output logic [7:0]    sram_data_o,
   input  logic [7:0]    sram_data_i,
   output logic          sram_data_oe,
   output logic          sram_we_n
);

   localparam int unsigned CW = $clog2(ACCESS_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic          grant_b;
   logic          last_grant_b;
   logic          we_lat;

   logic          start;
   logic          grant_nxt_b;
   logic [AW-1:0] sel_addr;
   logic [7:0]    sel_wdata;
   logic          sel_we;

   always_comb begin
      state_nxt   = state;
      start       = 1'b0;
      grant_nxt_b = 1'b0;
      case (state)
         IDLE: begin
            // On contention the port not served last wins.
            if (a_req && b_req) begin
               start       = 1'b1;
               grant_nxt_b = ~last_grant_b;
            end else if (a_req) begin
               start       = 1'b1;
               grant_nxt_b = 1'b0;
            end else if (b_req) begin
               start       = 1'b1;
               grant_nxt_b = 1'b1;
            end
            if (start) begin
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt == CNT_LAST) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sel_addr  = grant_nxt_b ? b_addr  : a_addr;
      sel_wdata = grant_nxt_b ? b_wdata : a_wdata;
      sel_we    = grant_nxt_b ? b_we    : a_we;
   end

   // WE# is held off on the first and last access cycles for setup and hold.
   always_comb begin
      sram_data_oe = (state == ACCESS) && we_lat;
      sram_we_n    = ~((state == ACCESS) && we_lat &&
                       (cnt != '0) && (cnt != CNT_LAST));
      a_ack        = (state == DONE) && !grant_b;
      b_ack        = (state == DONE) &&  grant_b;
   end

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         grant_b      <= 1'b0;
         last_grant_b <= 1'b1;
         we_lat       <= 1'b0;
         sram_addr    <= '0;
         sram_data_o  <= '0;
         a_rdata      <= '0;
         b_rdata      <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            grant_b      <= grant_nxt_b;
            last_grant_b <= grant_nxt_b;
            cnt          <= '0;
            we_lat       <= sel_we;
            sram_addr    <= sel_addr;
            sram_data_o  <= sel_wdata;
         end
         if (state == ACCESS) begin
            cnt <= cnt + CW'(1);
            if ((cnt == CNT_LAST) && !we_lat) begin
               if (grant_b) begin
                  b_rdata <= sram_data_i;
               end else begin
                  a_rdata <= sram_data_i;
               end
            end
         end
      end
   end

   a_one_ack: assert property (@(posedge sysclk) disable iff (!rst_n)
      !(a_ack && b_ack));

   a_we_with_oe: assert property (@(posedge sysclk) disable iff (!rst_n)
      !sram_we_n |-> sram_data_oe);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: behavioural SRAM, reference memory and
// serve-order model, directed scenarios plus randomized two-port traffic.
module tb_sram_arbiter;

   localparam int unsigned AW = 21;

   logic          sysclk = 1'b0;
   logic          rst_n  = 1'b0;
   logic          a_req = 1'b0, a_we = 1'b0;
   logic [AW-1:0] a_addr = '0;
   logic [7:0]    a_wdata = '0;
   logic          a_ack;
   logic [7:0]    a_rdata;
   logic          b_req = 1'b0, b_we = 1'b0;
   logic [AW-1:0] b_addr = '0;
   logic [7:0]    b_wdata = '0;
   logic          b_ack;
   logic [7:0]    b_rdata;
   logic [AW-1:0] sram_addr;
   logic [7:0]    sram_data_o;
   logic [7:0]    sram_data_i = '0;
   logic          sram_data_oe;
   logic          sram_we_n;

   sram_arbiter #(.ACCESS_CYCLES(4), .AW(AW)) dut (
      .sysclk(sysclk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .sram_addr(sram_addr), .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
      .sram_data_oe(sram_data_oe), .sram_we_n(sram_we_n)
   );

   always #5 sysclk = ~sysclk;

   int checks = 0;
   int failures = 0;
   int cycle = 0;
   int dual_ack_cnt = 0;
   int we_no_oe_cnt = 0;

   logic [7:0] mem     [logic [AW-1:0]];
   logic [7:0] ref_mem [logic [AW-1:0]];
   logic       last_served_b;
   logic [7:0] exp_a_rdata;

   function automatic logic [7:0] init_val(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h3C;
   endfunction

   function automatic logic [7:0] ref_read(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   always @(posedge sysclk) cycle++;

   // Async SRAM: writes while WE# is low, read data follows the address.
   always @(negedge sysclk) begin
      if (!sram_we_n) mem[sram_addr] = sram_data_o;
      if (!sram_we_n && !sram_data_oe) we_no_oe_cnt++;
      if (a_ack && b_ack) dual_ack_cnt++;
      sram_data_i = mem.exists(sram_addr) ? mem[sram_addr] : init_val(sram_addr);
   end

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL reset_we_n: got %b want 1", sram_we_n); end
      checks++; if (sram_data_oe !== 1'b0) begin failures++; $display("FAIL reset_oe: got %b want 0", sram_data_oe); end
      checks++; if ({a_ack, b_ack} !== 2'b00) begin failures++; $display("FAIL reset_ack: got %b want 00", {a_ack, b_ack}); end
      checks++; if (sram_addr !== '0) begin failures++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
      checks++; if (sram_data_o !== 8'h00) begin failures++; $display("FAIL reset_data_o: got %h want 00", sram_data_o); end
      checks++; if ({a_rdata, b_rdata} !== 16'h0000) begin failures++; $display("FAIL reset_rdata: got %h want 0000", {a_rdata, b_rdata}); end
      rst_n = 1'b1;
      last_served_b = 1'b1;
      exp_a_rdata = 8'h00;
      tick();
   endtask

   task automatic test_read();
      int n = 0;
      int we_low = 0;
      bit got = 0;
      mem[21'h1ABCD] = 8'h5A;
      ref_mem[21'h1ABCD] = 8'h5A;
      a_we = 1'b0; a_addr = 21'h1ABCD; a_wdata = 8'($urandom); a_req = 1'b1;
      while (n < 20 && !got) begin
         tick(); n++;
         if (!sram_we_n) we_low++;
         if (a_ack) got = 1;
      end
      a_req = 1'b0;
      exp_a_rdata = ref_read(21'h1ABCD);
      last_served_b = 1'b0;
      checks++; if (!got) begin failures++; $display("FAIL read_ack: no a_ack within 20 cycles"); end
      checks++; if (n != 5) begin failures++; $display("FAIL read_latency: got %0d want 5", n); end
      checks++; if (a_rdata !== exp_a_rdata) begin failures++; $display("FAIL read_data: got %h want %h", a_rdata, exp_a_rdata); end
      checks++; if (we_low != 0) begin failures++; $display("FAIL read_we_n: low %0d cycles want 0", we_low); end
      tick();
   endtask

   task automatic test_write();
      int n = 0, oe_cnt = 0, we_cnt = 0, bad_bus = 0;
      int first_oe = -1, last_oe = -1, first_we = -1, last_we = -1;
      bit got = 0;
      a_we = 1'b1; a_addr = 21'h000FF; a_wdata = 8'hC3; a_req = 1'b1;
      while (n < 20 && !got) begin
         tick(); n++;
         if (sram_data_oe) begin
            oe_cnt++;
            if (first_oe < 0) first_oe = n;
            last_oe = n;
            if (sram_addr !== 21'h000FF || sram_data_o !== 8'hC3) bad_bus++;
         end
         if (!sram_we_n) begin
            we_cnt++;
            if (first_we < 0) first_we = n;
            last_we = n;
         end
         if (a_ack) got = 1;
      end
      a_req = 1'b0;
      ref_mem[21'h000FF] = 8'hC3;
      last_served_b = 1'b0;
      checks++; if (!got) begin failures++; $display("FAIL write_ack: no a_ack within 20 cycles"); end
      checks++; if (we_cnt != 2) begin failures++; $display("FAIL write_we_len: got %0d want 2", we_cnt); end
      checks++; if (oe_cnt != 4) begin failures++; $display("FAIL write_oe_len: got %0d want 4", oe_cnt); end
      checks++; if (first_we != first_oe + 1) begin failures++; $display("FAIL write_setup: we at %0d oe at %0d", first_we, first_oe); end
      checks++; if (last_oe != last_we + 1) begin failures++; $display("FAIL write_hold: oe end %0d we end %0d", last_oe, last_we); end
      checks++; if (bad_bus != 0) begin failures++; $display("FAIL write_bus: %0d unstable cycles want 0", bad_bus); end
      checks++; if (!mem.exists(21'h000FF) || mem[21'h000FF] !== 8'hC3) begin failures++; $display("FAIL write_mem: value wrong want c3"); end
      checks++; if (a_rdata !== exp_a_rdata) begin failures++; $display("FAIL write_rdata_kept: got %h want %h", a_rdata, exp_a_rdata); end
      tick();
   endtask

   task automatic test_contention();
      bit port [4];
      int cyc [4];
      int k = 0;
      bit first_b;
      rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
      last_served_b = 1'b1; exp_a_rdata = 8'h00;
      a_we = 1'b0; a_addr = 21'h02000 | AW'($urandom_range(0, 255));
      b_we = 1'b0; b_addr = 21'h03000 | AW'($urandom_range(0, 255));
      a_req = 1'b1; b_req = 1'b1;
      for (int c = 0; c < 60 && k < 4; c++) begin
         tick();
         if (a_ack || b_ack) begin
            port[k] = b_ack && !a_ack;
            cyc[k] = cycle;
            if (a_ack) begin
               exp_a_rdata = ref_read(a_addr);
               checks++; if (a_rdata !== exp_a_rdata) begin failures++; $display("FAIL cont_a_rdata: got %h want %h", a_rdata, exp_a_rdata); end
            end else begin
               checks++; if (b_rdata !== ref_read(b_addr)) begin failures++; $display("FAIL cont_b_rdata: got %h want %h", b_rdata, ref_read(b_addr)); end
            end
            k++;
         end
      end
      a_req = 1'b0; b_req = 1'b0;
      checks++; if (k != 4) begin failures++; $display("FAIL cont_count: got %0d acks want 4", k); end
      first_b = !last_served_b;
      for (int i = 0; i < k; i++) begin
         checks++; if (port[i] != (first_b ^ i[0])) begin failures++; $display("FAIL cont_order[%0d]: got %s want %s", i, port[i] ? "B" : "A", (first_b ^ i[0]) ? "B" : "A"); end
         if (i > 0) begin
            checks++; if (cyc[i] - cyc[i-1] != 6) begin failures++; $display("FAIL cont_spacing[%0d]: got %0d want 6", i, cyc[i] - cyc[i-1]); end
         end
      end
      if (k > 0) last_served_b = port[k-1];
      tick();
   endtask

   task automatic test_reset_mid();
      bit seen_low = 0;
      bit first_set = 0, first_b = 0, got_a = 0, got_b = 0;
      a_we = 1'b1; a_addr = 21'h00123; a_wdata = 8'hA7; a_req = 1'b1;
      for (int c = 0; c < 20 && !seen_low; c++) begin
         tick();
         if (!sram_we_n) seen_low = 1;
      end
      checks++; if (!seen_low) begin failures++; $display("FAIL rstmid_we_low: we_n never low"); end
      b_we = 1'b0; b_addr = 21'h00124; b_req = 1'b1;
      rst_n = 1'b0;
      tick();
      checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL rstmid_we_n: got %b want 1", sram_we_n); end
      checks++; if (sram_data_oe !== 1'b0) begin failures++; $display("FAIL rstmid_oe: got %b want 0", sram_data_oe); end
      checks++; if ({a_ack, b_ack} !== 2'b00) begin failures++; $display("FAIL rstmid_ack: got %b want 00", {a_ack, b_ack}); end
      tick();
      checks++; if ({a_ack, b_ack} !== 2'b00) begin failures++; $display("FAIL rstmid_ack2: got %b want 00", {a_ack, b_ack}); end
      rst_n = 1'b1;
      last_served_b = 1'b1; exp_a_rdata = 8'h00;
      for (int c = 0; c < 40 && !(got_a && got_b); c++) begin
         tick();
         if ((a_ack || b_ack) && !first_set) begin first_set = 1; first_b = b_ack; end
         if (a_ack) begin got_a = 1; a_req = 1'b0; ref_mem[21'h00123] = 8'hA7; end
         if (b_ack) begin
            got_b = 1; b_req = 1'b0;
            checks++; if (b_rdata !== ref_read(21'h00124)) begin failures++; $display("FAIL rstmid_b_rdata: got %h want %h", b_rdata, ref_read(21'h00124)); end
         end
      end
      a_req = 1'b0; b_req = 1'b0;
      checks++; if (!(got_a && got_b)) begin failures++; $display("FAIL rstmid_both: a=%0d b=%0d want 1 1", got_a, got_b); end
      checks++; if (first_b != 1'b0) begin failures++; $display("FAIL rstmid_first: got B want A"); end
      checks++; if (!mem.exists(21'h00123) || mem[21'h00123] !== 8'hA7) begin failures++; $display("FAIL rstmid_mem: value wrong want a7"); end
      last_served_b = 1'b1;
      tick();
   endtask

   task automatic test_drop();
      int a_seen = 0, b_seen = 0, extra = 0, busy = 0, addr_chg = 0;
      logic [AW-1:0] baddr;
      logic [7:0] bdata;
      baddr = 21'h0A000 | AW'($urandom_range(0, 4095));
      bdata = 8'($urandom);
      b_we = 1'b1; b_addr = baddr; b_wdata = bdata; b_req = 1'b1;
      tick();
      tick();
      a_we = 1'b0; a_addr = 21'h0B000 | AW'($urandom_range(0, 4095)); a_req = 1'b1;
      tick();
      if (a_ack) a_seen++;
      a_req = 1'b0;
      for (int c = 0; c < 20 && b_seen == 0; c++) begin
         tick();
         if (a_ack) a_seen++;
         if (b_ack) begin b_seen++; b_req = 1'b0; end
      end
      ref_mem[baddr] = bdata;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (a_ack || b_ack) extra++;
         if (sram_data_oe || !sram_we_n) busy++;
         if (sram_addr !== baddr) addr_chg++;
      end
      checks++; if (b_seen != 1) begin failures++; $display("FAIL drop_b_ack: got %0d want 1", b_seen); end
      checks++; if (a_seen != 0) begin failures++; $display("FAIL drop_a_ack: got %0d want 0", a_seen); end
      checks++; if (extra != 0) begin failures++; $display("FAIL drop_idle_ack: got %0d want 0", extra); end
      checks++; if (busy != 0) begin failures++; $display("FAIL drop_idle_bus: got %0d busy cycles want 0", busy); end
      checks++; if (addr_chg != 0) begin failures++; $display("FAIL drop_addr_hold: got %0d changes want 0", addr_chg); end
      checks++; if (!mem.exists(baddr) || mem[baddr] !== bdata) begin failures++; $display("FAIL drop_b_mem: want %h", bdata); end
      last_served_b = 1'b1;
   endtask

   task automatic test_back_to_back();
      int c1 = -1, c2 = -1;
      logic [AW-1:0] at2;
      b_we = 1'b0; b_addr = 21'h000FF; b_req = 1'b1;
      for (int c = 0; c < 20 && c1 < 0; c++) begin
         tick();
         if (b_ack) c1 = cycle;
      end
      checks++; if (b_rdata !== ref_read(21'h000FF)) begin failures++; $display("FAIL b2b_first_rdata: got %h want %h", b_rdata, ref_read(21'h000FF)); end
      b_addr = 21'h1ABCD;
      for (int c = 0; c < 20 && c2 < 0; c++) begin
         tick();
         if (b_ack) begin c2 = cycle; at2 = sram_addr; end
      end
      b_req = 1'b0;
      checks++; if (c1 < 0 || c2 < 0 || c2 - c1 != 6) begin failures++; $display("FAIL b2b_spacing: got %0d want 6", c2 - c1); end
      checks++; if (at2 !== 21'h1ABCD) begin failures++; $display("FAIL b2b_addr: got %h want 1abcd", at2); end
      checks++; if (b_rdata !== ref_read(21'h1ABCD)) begin failures++; $display("FAIL b2b_second_rdata: got %h want %h", b_rdata, ref_read(21'h1ABCD)); end
      checks++; if (a_rdata !== exp_a_rdata) begin failures++; $display("FAIL b2b_a_rdata_kept: got %h want %h", a_rdata, exp_a_rdata); end
      last_served_b = 1'b1;
      tick();
   endtask

   task automatic drive_port(input bit is_b);
      for (int t = 0; t < 14; t++) begin
         logic [AW-1:0] ad;
         logic          w;
         logic [7:0]    d;
         logic [7:0]    rd;
         bit            got;
         int            gap;
         ad = 21'h10000 | AW'($urandom_range(0, 7));
         w = 1'($urandom_range(0, 1));
         d = 8'($urandom);
         got = 0;
         if (is_b) begin b_addr = ad; b_we = w; b_wdata = d; b_req = 1'b1; end
         else      begin a_addr = ad; a_we = w; a_wdata = d; a_req = 1'b1; end
         for (int c = 0; c < 40 && !got; c++) begin
            tick();
            if (is_b ? b_ack : a_ack) got = 1;
         end
         if (is_b) b_req = 1'b0; else a_req = 1'b0;
         checks++;
         if (!got) begin
            failures++; $display("FAIL rand_timeout: port %s txn %0d got no ack want ack", is_b ? "B" : "A", t);
         end else if (w) begin
            ref_mem[ad] = d;
         end else begin
            rd = is_b ? b_rdata : a_rdata;
            if (!is_b) exp_a_rdata = ref_read(ad);
            checks++;
            if (rd !== ref_read(ad)) begin failures++; $display("FAIL rand_rdata: port %s addr %h got %h want %h", is_b ? "B" : "A", ad, rd, ref_read(ad)); end
         end
         gap = $urandom_range(0, 3);
         repeat (gap) tick();
      end
   endtask

   task automatic test_random();
      fork
         drive_port(1'b0);
         drive_port(1'b1);
      join
      tick();
   endtask

   task automatic test_invariants();
      checks++; if (dual_ack_cnt != 0) begin failures++; $display("FAIL inv_dual_ack: got %0d cycles want 0", dual_ack_cnt); end
      checks++; if (we_no_oe_cnt != 0) begin failures++; $display("FAIL inv_we_without_oe: got %0d cycles want 0", we_no_oe_cnt); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_read();
      test_write();
      test_contention();
      test_reset_mid();
      test_drop();
      test_back_to_back();
      test_random();
      test_invariants();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
